prog_sequencer: RTL

Parametrised fetch sequencer for the 3BC processor family. It replaces the separate program-counter enable and program-counter blocks with one unit. The unit owns the Start/Ack program handshake, selects one of several program entry points, and generates the program counter with absolute or relative branching, halt and stall. It also keeps saturating cycle and instruction counters. It drives the instruction ROM address and takes its branch, halt and stall controls from the decoder.

---
 rtl/prog_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/prog_sequencer.sv
// Fetch sequencer for the 3BC processor family.
// Owns the Start/Ack program handshake and selects the program entry point.
// Generates the program counter with absolute/relative branch, halt and stall.
// Keeps saturating cycle and instruction counters. Every output is registered.
module prog_sequencer #(
    parameter int PC_W         = 10,
    parameter int CNT_W        = 16,
    parameter int NUM_PROGS    = 3,
    parameter int SEL_W        = 2,
    parameter int ENTRY_STRIDE = 256
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [SEL_W-1:0] ProgSel,
    input  logic             BranchEn,
    input  logic             BranchAbs,
    input  logic [PC_W-1:0]  Target,
    input  logic             Halt,
    input  logic             Stall,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Fetch,
    output logic             Ack,
    output logic             Busy,
    output logic             PcWrap,
    output logic [CNT_W-1:0] CycleCt,
    output logic [CNT_W-1:0] InstCt
);

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} seqState_t;

    seqState_t        state;
    seqState_t        stateNext;
    logic [PC_W-1:0]  pcNext;
    logic             wrapNext;
    logic [CNT_W-1:0] cycleNext;
    logic [CNT_W-1:0] instNext;
    logic [PC_W-1:0]  entryPc;
    logic [PC_W+1:0]  relSum;
    logic [CNT_W-1:0] cycleSat;
    logic [CNT_W-1:0] instSat;

    // Out-of-range selects fall back to entry 0.
    assign entryPc = (int'(ProgSel) < NUM_PROGS) ? PC_W'(int'(ProgSel) * ENTRY_STRIDE) : '0;

    // Two guard bits catch both carry-out (01) and borrow-out (11) of a relative branch.
    assign relSum = {2'b00, ProgCtr} + {{2{Target[PC_W-1]}}, Target};

    // Saturating increments: the counters stick at all-ones instead of wrapping.
    assign cycleSat = (&CycleCt) ? CycleCt : CycleCt + CNT_W'(1);
    assign instSat  = (&InstCt)  ? InstCt  : InstCt  + CNT_W'(1);

    // State register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of block ordering.
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // Next-state, next-PC, wrap flag and counter updates.
    always_comb begin
        // NOTE: every signal gets a hold default first, so no path infers a latch.
        stateNext = state;
        pcNext    = ProgCtr;
        wrapNext  = PcWrap;
        cycleNext = CycleCt;
        instNext  = InstCt;
        case (state)
            IDLE, DONE: begin
                if (Start) begin
                    stateNext = ARMED;
                    pcNext    = entryPc;
                    wrapNext  = 1'b0;
                    cycleNext = '0;
                    instNext  = '0;
                end
            end
            ARMED: begin
                if (!Start) stateNext = RUN;
            end
            RUN: begin
                cycleNext = cycleSat;
                if (!Stall) begin
                    instNext = instSat;
                    if (Halt) begin
                        stateNext = DONE;
                    end else if (BranchEn && BranchAbs) begin
                        pcNext = Target;
                    end else if (BranchEn) begin
                        pcNext = relSum[PC_W-1:0];
                        if (relSum[PC_W+1:PC_W] != 2'b00) wrapNext = 1'b1;
                    end else begin
                        pcNext = ProgCtr + PC_W'(1);
                        if (&ProgCtr) wrapNext = 1'b1;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Output registers; status flags are decoded from the next state so they track the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ProgCtr <= '0;
            PcWrap  <= 1'b0;
            CycleCt <= '0;
            InstCt  <= '0;
            Fetch   <= 1'b0;
            Ack     <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            ProgCtr <= pcNext;
            PcWrap  <= wrapNext;
            CycleCt <= cycleNext;
            InstCt  <= instNext;
            Fetch   <= (stateNext == RUN);
            Ack     <= (stateNext == DONE);
            Busy    <= (stateNext == ARMED) || (stateNext == RUN);
        end
    end

endmodule
